f2f_arbiter: RTL

Shares one registered fixed-to-float conversion pipeline between `NREQ` CORDIC result producers. Each producer offers an unsigned fixed-point cosine magnitude (range 0.5403–1.0) over a valid/ready handshake. A round-robin arbiter grants one producer per cycle, and a two-stage pipeline converts the value to IEEE-754 single precision. Results are returned tagged with the requester index. The block sits between the CORDIC cores and the custom-instruction result mux.

---
 rtl/f2f_arbiter.sv | 91 +++++++++
 1 files changed

// File: rtl/f2f_arbiter.sv
// f2f_arbiter: round-robin shared fixed-to-float pipeline; define F2F_ARB_PRIO0_EN to give requester 0 fixed priority
module f2f_arbiter #(
  parameter int NREQ  = 4,
  parameter int FRACS = 20,
  parameter int INTS  = 1,
  parameter int WIDTH = INTS + FRACS,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  out_range_err
);
`ifdef F2F_ARB_PRIO0_EN
  localparam logic PRIO0 = 1'b1;
`else
  localparam logic PRIO0 = 1'b0;
`endif
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_data;
  logic [IDW-1:0]   r_s1_id;
  logic [IDW-1:0]   r_ptr;
  logic             w_s2_load;
  logic             w_s1_free;
  logic             w_found;
  logic             w_acc;
  logic [IDW-1:0]   w_g;
  logic [IDW-1:0]   w_idx;
  logic [22:0]      w_man;
  logic [31:0]      w_fp;
  logic [WIDTH-1:0] w_words [NREQ];
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_words[i] = req_data[i*WIDTH +: WIDTH];
  end
  assign w_s2_load = r_s1_valid && (!out_valid || out_ready);
  assign w_s1_free = !r_s1_valid || w_s2_load;
  always_comb begin
    w_g = '0;
    w_idx = '0;
    w_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = IDW'((int'(r_ptr) + k) % NREQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_g = w_idx;
      end
    end
    if (PRIO0 && req_valid[0]) begin
      w_found = 1'b1;
      w_g = '0;
    end
  end
  assign w_acc     = w_found && w_s1_free && !reset;
  assign req_ready = w_acc ? NREQ'(1) << w_g : '0;
  // MSB clear means 0.5 <= x < 1: exponent fixed at 126, bit WIDTH-2 is the hidden one
  assign w_man = 23'(r_s1_data[WIDTH-3:0]) << (24 - FRACS);
  assign w_fp  = r_s1_data[WIDTH-1] ? 32'h3F80_0000 : {1'b0, 8'd126, w_man};
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_s1_data <= w_words[w_g];
      r_s1_id   <= w_g;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid    <= 1'b0;
      r_ptr         <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_id        <= '0;
      out_range_err <= 1'b0;
    end else begin
      if (w_s1_free) r_s1_valid <= w_acc;
      if (w_acc && !(PRIO0 && w_g == '0)) r_ptr <= IDW'((int'(w_g) + 1) % NREQ);
      if (w_s2_load) begin
        out_valid     <= 1'b1;
        out_data      <= w_fp;
        out_id        <= r_s1_id;
        out_range_err <= !r_s1_data[WIDTH-1] && !r_s1_data[WIDTH-2];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
